// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types used by the fetch stage: machine word, opcode field, fetch FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef enum logic [1:0] {
    fs_req,
    fs_idle,
    fs_drop
  } lc3b_fetch_state;

  localparam lc3b_word RESET_PC_DEFAULT = 16'h0000;

  // Next sequential instruction address; wraps modulo 2^16, bit 0 is not touched.
  function automatic lc3b_word pc_inc(input lc3b_word addr);
    return addr + 16'd2;
  endfunction

endpackage

// File: rtl/lc3b_fetch_hold.sv
// One-entry skid register that parks a fetched word while decode is stalled.
module lc3b_fetch_hold
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load_i,
  input  logic     drain_i,
  input  logic     clear_i,
  input  lc3b_word pc_i,
  input  lc3b_word ir_i,
  output lc3b_word pc_o,
  output lc3b_word ir_o,
  output logic     valid_o
);

  lc3b_word pc_q, ir_q;
  logic     valid_q;

  // Clear (redirect) and drain both empty the entry and take priority over a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
    end else if (clear_i || drain_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      ir_q    <= ir_i;
    end
  end

  assign pc_o    = pc_q;
  assign ir_o    = ir_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction fetch: imem read handshake, PC, stall skid buffer, redirect flush,
// and the IF/ID pipeline register.
module lc3b_fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output lc3b_word   imem_address,
  output logic       imem_read,
  input  logic       imem_resp,
  input  lc3b_word   imem_rdata,
  input  logic       stall,
  input  logic       redirect,
  input  lc3b_word   redirect_pc,
  output logic       if_id_valid,
  output lc3b_word   if_id_pc,
  output lc3b_word   if_id_ir,
  output lc3b_opcode if_id_opcode
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        req_addr_q, req_addr_d;
  logic            if_id_valid_q, if_id_valid_d;
  lc3b_word        if_id_pc_q, if_id_pc_d;
  lc3b_word        if_id_ir_q, if_id_ir_d;

  logic     hold_load, hold_drain, hold_clear, hold_valid;
  lc3b_word hold_pc, hold_ir;

  lc3b_fetch_hold u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .clear_i (hold_clear),
    .pc_i    (pc_inc(req_addr_q)),
    .ir_i    (imem_rdata),
    .pc_o    (hold_pc),
    .ir_o    (hold_ir),
    .valid_o (hold_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= fs_req;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_ir_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_ir_q    <= if_id_ir_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_ir_d    = if_id_ir_q;
    hold_load     = 1'b0;
    hold_drain    = 1'b0;
    hold_clear    = 1'b0;

    if (redirect) begin
      if_id_valid_d = 1'b0;
      hold_clear    = 1'b1;
      pc_d          = redirect_pc;
      unique case (state_q)
        // A read still in flight must finish on its old address, so park in DROP.
        fs_req: begin
          if (imem_resp) req_addr_d = redirect_pc;
          else           state_d    = fs_drop;
        end
        fs_idle: begin
          state_d    = fs_req;
          req_addr_d = redirect_pc;
        end
        default: ;
      endcase
    end else begin
      unique case (state_q)
        fs_req: begin
          if (imem_resp) begin
            pc_d = pc_inc(req_addr_q);
            if (!stall) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_inc(req_addr_q);
              if_id_ir_d    = imem_rdata;
              req_addr_d    = pc_inc(req_addr_q);
            end else begin
              hold_load = 1'b1;
              state_d   = fs_idle;
            end
          end else if (!stall) begin
            if_id_valid_d = 1'b0;
          end
        end
        fs_idle: begin
          if (!stall && hold_valid) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = hold_pc;
            if_id_ir_d    = hold_ir;
            hold_drain    = 1'b1;
            state_d       = fs_req;
            req_addr_d    = pc_q;
          end
        end
        fs_drop: begin
          if (imem_resp) begin
            state_d    = fs_req;
            req_addr_d = pc_q;
          end
        end
        default: state_d = fs_req;
      endcase
    end
  end

  assign imem_read    = (state_q != fs_idle);
  assign imem_address = req_addr_q;
  assign if_id_valid  = if_id_valid_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_ir     = if_id_ir_q;
  assign if_id_opcode = lc3b_opcode'(if_id_ir_q[15:12]);

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Randomized bench for lc3b_fetch_stage against a transaction-level fetch model.
module tb_lc3b_fetch_stage;
  import lc3b_types::*;

  localparam logic [15:0] TB_RESET_PC = 16'hFFFE;
  localparam int          N_CYCLES    = 1500;

  logic       clk = 1'b0;
  logic       reset;
  lc3b_word   imem_address;
  logic       imem_read;
  logic       imem_resp;
  lc3b_word   imem_rdata;
  logic       stall;
  logic       redirect;
  lc3b_word   redirect_pc;
  logic       if_id_valid;
  lc3b_word   if_id_pc;
  lc3b_word   if_id_ir;
  lc3b_opcode if_id_opcode;

  lc3b_fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_ir     (if_id_ir),
    .if_id_opcode (if_id_opcode)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: a fetch is either reading (address m_addr), reading-to-discard, or parked
  // with one fetched word waiting in m_parked.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } parked_t;

  parked_t     m_parked[$];
  logic [15:0] m_pc, m_addr, m_ifpc, m_ir;
  logic        m_discard, m_vld;

  task automatic model_reset();
    m_parked.delete();
    m_pc      = TB_RESET_PC;
    m_addr    = TB_RESET_PC;
    m_discard = 1'b0;
    m_vld     = 1'b0;
    m_ifpc    = 16'h0000;
    m_ir      = 16'h0000;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [15:0] rpc,
                            input logic rsp, input logic [15:0] word);
    bit      was_parked;
    parked_t p;
    was_parked = (m_parked.size() != 0);
    if (rd) begin
      m_vld = 1'b0;
      m_parked.delete();
      m_pc = rpc;
      if (!m_discard) begin
        if (was_parked || rsp) m_addr = rpc;
        else                   m_discard = 1'b1;
      end
    end else if (m_discard) begin
      if (rsp) begin
        m_discard = 1'b0;
        m_addr    = m_pc;
      end
    end else if (was_parked) begin
      if (!st) begin
        p      = m_parked.pop_front();
        m_ifpc = p.pc;
        m_ir   = p.ir;
        m_vld  = 1'b1;
        m_addr = m_pc;
        $display("[TB] deliver (from hold) pc=%h ir=%h", m_ifpc, m_ir);
      end
    end else if (rsp) begin
      m_pc = m_addr + 16'd2;
      if (!st) begin
        m_ifpc = m_addr + 16'd2;
        m_ir   = word;
        m_vld  = 1'b1;
        m_addr = m_addr + 16'd2;
        $display("[TB] deliver pc=%h ir=%h", m_ifpc, m_ir);
      end else begin
        m_parked.push_back('{pc: m_addr + 16'd2, ir: word});
      end
    end else if (!st) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic exp_read;
    exp_read = (m_parked.size() == 0);
    check_eq("imem_read", imem_read, exp_read);
    if (exp_read) check_eq("imem_address", imem_address, m_addr);
    check_eq("if_id_valid", if_id_valid, m_vld);
    check_eq("if_id_pc", if_id_pc, m_ifpc);
    check_eq("if_id_ir", if_id_ir, m_ir);
    check_eq("if_id_opcode", if_id_opcode, {28'd0, m_ir[15:12]});
  endtask

  task automatic check_reset_values();
    check_eq("rst_imem_read", imem_read, 1'b1);
    check_eq("rst_imem_address", imem_address, TB_RESET_PC);
    check_eq("rst_if_id_valid", if_id_valid, 1'b0);
    check_eq("rst_if_id_pc", if_id_pc, 16'h0000);
    check_eq("rst_if_id_ir", if_id_ir, 16'h0000);
    check_eq("rst_if_id_opcode", if_id_opcode, op_br);
  endtask

  initial begin
    bit done_mid_reset;
    done_mid_reset = 1'b0;
    reset       = 1'b1;
    imem_resp   = 1'b0;
    imem_rdata  = 16'h0000;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      reset = 1'b0;
      check_outputs();

      // Asynchronous reset while the hold is full: outputs must drop immediately.
      if (!done_mid_reset && cyc >= N_CYCLES / 2 && m_parked.size() != 0) begin
        done_mid_reset = 1'b1;
        imem_resp = 1'b0;
        redirect  = 1'b0;
        reset     = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        continue;
      end

      imem_resp   = (m_parked.size() == 0) && ($urandom_range(0, 2) == 0);
      imem_rdata  = 16'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom);
      if (redirect)
        $display("[TB] redirect to %h (resp=%0d stall=%0d)", redirect_pc, imem_resp, stall);
      model_step(stall, redirect, redirect_pc, imem_resp, imem_rdata);
    end

    @(negedge clk);
    check_outputs();
    check_eq("mid_reset_exercised", {31'd0, done_mid_reset}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
